// File: rtl/feature_pkg.sv
// rtl/feature_pkg.sv - shared widths and types for the feature descriptor datapath
package feature_pkg;

   localparam int DW     = 128;
   localparam int REC_XW = 10;
   localparam int REC_YW = 9;

   typedef struct packed {
      logic [REC_XW-1:0] x;
      logic [REC_YW-1:0] y;
      logic [DW-1:0]     desc;
   } feat_rec_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/feat_fifo.sv
// rtl/feat_fifo.sv - first-word-fall-through record FIFO
module feat_fifo
   import feature_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  feat_rec_t              push_data,
   input  logic                   pop,
   output feat_rec_t              head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   feat_rec_t      mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (!do_push && do_pop)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/feature_desc_ctrl.sv
// rtl/feature_desc_ctrl.sv - raster tracking, descriptor capture and record queueing
module feature_desc_ctrl
   import feature_pkg::*;
#(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int XW         = 10,
   parameter int YW         = 9,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_FEAT   = 512
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          win_valid,
   input  logic                          win_sof,
   input  logic                          win_keypoint,
   input  logic [DW-1:0]                 desc_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [XW-1:0]                 out_x,
   output logic [YW-1:0]                 out_y,
   output logic [DW-1:0]                 out_desc,
   output logic [$clog2(MAX_FEAT+1)-1:0] feat_cnt,
   output logic [15:0]                   drop_cnt,
   output logic                          frame_done,
   output logic                          frame_err
);

   localparam int            CW     = $clog2(MAX_FEAT+1);
   localparam logic [XW-1:0] LAST_X = XW'(IMG_W-1);
   localparam logic [YW-1:0] LAST_Y = YW'(IMG_H-1);
   localparam logic [CW-1:0] CAP    = CW'(MAX_FEAT);

   ctrl_state_t               state;
   logic [XW-1:0]             col;
   logic [YW-1:0]             row;
   logic                      pend_v;
   logic [XW-1:0]             pend_x;
   logic [YW-1:0]             pend_y;
   logic                      pop;
   logic                      push;
   logic                      drop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                      unused_count;
   feat_rec_t                 push_rec;
   feat_rec_t                 head_rec;

   assign pop          = !fifo_empty && out_ready;
   assign unused_count = ^fifo_count;

   always_comb begin
      push = 1'b0;
      drop = 1'b0;
      if (pend_v) begin
         if (feat_cnt == CAP || (fifo_full && !pop))
            drop = 1'b1;
         else
            push = 1'b1;
      end
   end

   always_comb begin
      push_rec      = '0;
      push_rec.x    = REC_XW'(pend_x);
      push_rec.y    = REC_YW'(pend_y);
      push_rec.desc = desc_in;
   end

   feat_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_rec),
      .pop       (pop),
      .head      (head_rec),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Outputs read zero while empty so stale memory never shows after reset.
   assign out_valid = !fifo_empty;
   assign out_x     = out_valid ? head_rec.x[XW-1:0] : '0;
   assign out_y     = out_valid ? head_rec.y[YW-1:0] : '0;
   assign out_desc  = out_valid ? head_rec.desc : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         pend_v     <= 1'b0;
         pend_x     <= '0;
         pend_y     <= '0;
         feat_cnt   <= '0;
         drop_cnt   <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         pend_v     <= 1'b0;
         if (push)
            feat_cnt <= feat_cnt + 1'b1;
         if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 1'b1;

         // SOF restarts the frame from any state; the clear overrides this cycle's push count.
         if (win_valid && win_sof) begin
            frame_err <= (state != IDLE);
            state     <= ACTIVE;
            col       <= XW'(1);
            row       <= '0;
            feat_cnt  <= '0;
            pend_v    <= win_keypoint;
            pend_x    <= '0;
            pend_y    <= '0;
         end else begin
            case (state)
               ACTIVE: begin
                  if (win_valid) begin
                     pend_v <= win_keypoint;
                     pend_x <= col;
                     pend_y <= row;
                     if (col == LAST_X) begin
                        col <= '0;
                        row <= row + 1'b1;
                        if (row == LAST_Y)
                           state <= FLUSH;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
               FLUSH: begin
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_feature_desc_ctrl.sv
// tb/tb_feature_desc_ctrl.sv - randomized scoreboard bench for feature_desc_ctrl
module tb_feature_desc_ctrl;

   localparam int W     = 8;
   localparam int H     = 4;
   localparam int DEPTH = 16;
   localparam int MAXF  = 24;
   localparam int CW    = $clog2(MAXF+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          win_valid;
   logic          win_sof;
   logic          win_keypoint;
   logic [127:0]  desc_in;
   logic          out_valid;
   logic          out_ready;
   logic [9:0]    out_x;
   logic [8:0]    out_y;
   logic [127:0]  out_desc;
   logic [CW-1:0] feat_cnt;
   logic [15:0]   drop_cnt;
   logic          frame_done;
   logic          frame_err;

   always #5 clk = ~clk;

   feature_desc_ctrl #(
      .IMG_W      (W),
      .IMG_H      (H),
      .XW         (10),
      .YW         (9),
      .FIFO_DEPTH (DEPTH),
      .MAX_FEAT   (MAXF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .win_valid    (win_valid),
      .win_sof      (win_sof),
      .win_keypoint (win_keypoint),
      .desc_in      (desc_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_x        (out_x),
      .out_y        (out_y),
      .out_desc     (out_desc),
      .feat_cnt     (feat_cnt),
      .drop_cnt     (drop_cnt),
      .frame_done   (frame_done),
      .frame_err    (frame_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   typedef struct {
      int           x;
      int           y;
      logic [127:0] d;
   } rec_t;

   rec_t exp_q[$];
   int   m_occ = 0, m_fc = 0, m_dc = 0, m_idx = 0, m_px = 0, m_py = 0;
   bit   m_in_frame = 0, m_flushing = 0, m_pv = 0, m_fd = 0, m_fe = 0, m_after_rst = 0;

   // Reference model: linear window index within the frame, record queue as the FIFO.
   always @(posedge clk) begin : model
      bit was_in, was_flush, popped, accepted;
      if (rst) begin
         m_occ = 0; m_fc = 0; m_dc = 0; m_idx = 0;
         m_in_frame = 0; m_flushing = 0; m_pv = 0; m_fd = 0; m_fe = 0;
         m_after_rst = 1;
         exp_q.delete();
      end else begin
         m_after_rst = 0;
         popped   = out_ready && (m_occ > 0);
         accepted = 0;
         m_fd = 0;
         m_fe = 0;
         if (m_pv) begin
            if (m_fc >= MAXF || (m_occ == DEPTH && !popped)) begin
               if (m_dc < 65535) m_dc++;
            end else begin
               exp_q.push_back('{m_px, m_py, desc_in});
               m_fc++;
               accepted = 1;
            end
         end
         m_occ = m_occ - (popped ? 1 : 0) + (accepted ? 1 : 0);

         was_in    = m_in_frame;
         was_flush = m_flushing;
         m_pv      = 0;
         if (win_valid && win_sof) begin
            m_fe = was_in || was_flush;
            m_in_frame = 1; m_flushing = 0;
            m_fc = 0;
            m_pv = win_keypoint; m_px = 0; m_py = 0;
            m_idx = 1;
         end else if (was_flush) begin
            m_fd = 1;
            m_flushing = 0;
         end else if (was_in && win_valid) begin
            m_pv = win_keypoint;
            m_px = m_idx % W;
            m_py = m_idx / W;
            m_idx++;
            if (m_idx == W*H) begin
               m_in_frame = 0;
               m_flushing = 1;
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      rec_t r;
      chk("out_valid", out_valid, m_occ > 0);
      chk("feat_cnt", feat_cnt, m_fc);
      chk("drop_cnt", drop_cnt, m_dc);
      chk("frame_done", frame_done, m_fd);
      chk("frame_err", frame_err, m_fe);
      if (m_after_rst) begin
         chk("rst_out_x", out_x, 0);
         chk("rst_out_y", out_y, 0);
         chk("rst_out_desc", out_desc, 0);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_record", 1, 0);
         end else begin
            r = exp_q.pop_front();
            chk("rec_x", out_x, r.x);
            chk("rec_y", out_y, r.y);
            chk("rec_desc", out_desc, r.d);
         end
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step(input logic v, input logic s, input logic k, input logic r, input logic [127:0] d);
      win_valid    = v;
      win_sof      = s;
      win_keypoint = k;
      out_ready    = r;
      desc_in      = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] a5;
      a5 = {4{32'hA5A5A5A5}};
      rst = 1'b1;
      win_valid = 0; win_sof = 0; win_keypoint = 0; out_ready = 0; desc_in = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // single keypoint at (3,2)
      for (int i = 0; i < W*H; i++) step(1, i == 0, i == 2*W+3, 1, a5);
      repeat (4) step(0, 0, 0, 1, a5);

      // 20 consecutive keypoints with the sink stalled
      for (int i = 0; i < W*H; i++) step(1, i == 0, i < 20, 0, rnd128());
      repeat (3) step(0, 0, 0, 0, rnd128());
      chk("stall_drop_cnt", drop_cnt, 4);
      chk("stall_feat_cnt", feat_cnt, 16);
      repeat (20) step(0, 0, 0, 1, rnd128());

      // every window a keypoint: per-frame cap
      for (int i = 0; i < W*H; i++) step(1, i == 0, 1, 1, rnd128());
      repeat (3) step(0, 0, 0, 1, rnd128());
      chk("cap_feat_cnt", feat_cnt, MAXF);
      chk("cap_drop_cnt", drop_cnt, 12);
      step(1, 1, 0, 1, rnd128());
      chk("sof_clears_feat", feat_cnt, 0);
      for (int i = 1; i < W*H; i++) step(1, 0, 0, 1, rnd128());
      repeat (3) step(0, 0, 0, 1, rnd128());

      // push onto a full FIFO while it pops
      for (int i = 0; i < W*H; i++) step(1, i == 0, i <= 16, i >= 17, rnd128());
      chk("full_pushpop_drop", drop_cnt, 12);
      chk("full_pushpop_feat", feat_cnt, 17);
      repeat (20) step(0, 0, 0, 1, rnd128());

      // SOF at window (5,1)
      for (int i = 0; i < W+5; i++) step(1, i == 0, i == 3, 1, rnd128());
      step(1, 1, 0, 1, rnd128());
      chk("midframe_err", frame_err, 1);
      chk("midframe_no_done", frame_done, 0);
      step(1, 0, 1, 1, rnd128());
      for (int i = 2; i < W*H; i++) step(1, 0, i == 9, 1, rnd128());
      repeat (3) step(0, 0, 0, 1, rnd128());

      // reset mid-frame with records queued
      for (int i = 0; i < 10; i++) step(1, i == 0, 1, 0, rnd128());
      rst = 1'b1;
      step(1, 0, 1, 0, rnd128());
      rst = 1'b0;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_feat", feat_cnt, 0);
      chk("rst_mid_drop", drop_cnt, 0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 999) == 0);
         step($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0,
              $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6, rnd128());
      end
      rst = 1'b0;
      repeat (40) step(0, 0, 0, 1, rnd128());
      chk("drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
